// File: rtl/load_store_unit.sv
// MEM-stage load/store unit for RV32I: sign/zero extension, sub-word read-modify-write,
// and word-crossing misaligned accesses split over two cycles.
module load_store_unit (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  input  logic        req_we,
  input  logic [2:0]  funct3,
  input  logic [31:0] addr,
  input  logic [31:0] store_data,
  output logic        busy,
  output logic        done,
  output logic        illegal,
  output logic [31:0] load_result,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata
);

  typedef enum logic {IDLE, SECOND} state_t;

  state_t      state_q, state_d;
  logic [29:0] hi_word_q;
  logic [2:0]  funct3_q;
  logic        we_q;
  logic [31:0] sdata_q;
  logic [1:0]  off_q;
  logic [31:0] hold_q;

  logic [1:0]  off;
  logic        legal, crosses, capture;
  logic [4:0]  sh_lo;
  logic [5:0]  sh_hi;
  logic [31:0] mask_lo, mask_hi, wdata_lo, wdata_hi;

  function automatic logic [31:0] size_mask(input logic [1:0] sz);
    case (sz)
      2'b00:   return 32'h0000_00FF;
      2'b01:   return 32'h0000_FFFF;
      default: return 32'hFFFF_FFFF;
    endcase
  endfunction

  function automatic logic [31:0] extend(input logic [31:0] raw, input logic [2:0] f3);
    case (f3)
      3'b000:  return {{24{raw[7]}}, raw[7:0]};
      3'b001:  return {{16{raw[15]}}, raw[15:0]};
      3'b100:  return {24'h0, raw[7:0]};
      3'b101:  return {16'h0, raw[15:0]};
      default: return raw;
    endcase
  endfunction

  assign off = addr[1:0];

  // Lane steering: the low access places data bytes from lane off upward, the high
  // access takes the data bytes that did not fit, starting at lane 0.
  always_comb begin
    case (funct3)
      3'b000, 3'b001, 3'b010: legal = 1'b1;
      3'b100, 3'b101:         legal = !req_we;
      default:                legal = 1'b0;
    endcase
    crosses  = (funct3[1:0] == 2'b01 && off == 2'b11) ||
               (funct3[1:0] == 2'b10 && off != 2'b00);
    sh_lo    = {off, 3'b000};
    sh_hi    = {3'd4 - {1'b0, off_q}, 3'b000};
    mask_lo  = size_mask(funct3[1:0]) << sh_lo;
    wdata_lo = (mem_rdata & ~mask_lo) | ((store_data << sh_lo) & mask_lo);
    mask_hi  = size_mask(funct3_q[1:0]) >> sh_hi;
    wdata_hi = (mem_rdata & ~mask_hi) | ((sdata_q >> sh_hi) & mask_hi);
  end

  // NOTE: every output gets a default before the case so no path infers a latch.
  always_comb begin
    state_d     = state_q;
    capture     = 1'b0;
    busy        = 1'b0;
    done        = 1'b0;
    illegal     = 1'b0;
    load_result = '0;
    mem_we      = 1'b0;
    mem_addr    = {addr[31:2], 2'b00};
    mem_wdata   = wdata_lo;

    case (state_q)
      IDLE: begin
        if (req_valid) begin
          if (!legal) begin
            illegal = 1'b1;
            done    = 1'b1;
          end else if (crosses) begin
            busy    = 1'b1;
            mem_we  = req_we;
            capture = 1'b1;
            state_d = SECOND;
          end else begin
            done   = 1'b1;
            mem_we = req_we;
            if (!req_we) load_result = extend(mem_rdata >> sh_lo, funct3);
          end
        end
      end
      SECOND: begin
        mem_addr  = {hi_word_q, 2'b00};
        mem_wdata = wdata_hi;
        mem_we    = we_q;
        done      = 1'b1;
        if (!we_q) load_result = extend(hold_q | (mem_rdata << sh_hi), funct3_q);
        state_d   = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // Reset silences the handshake immediately, even mid-access.
    if (rst) begin
      busy        = 1'b0;
      done        = 1'b0;
      illegal     = 1'b0;
      mem_we      = 1'b0;
      load_result = '0;
    end
  end

  // NOTE: holding registers are few and narrow, so they are all cleared on reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      hi_word_q <= '0;
      funct3_q  <= '0;
      we_q      <= 1'b0;
      sdata_q   <= '0;
      off_q     <= '0;
      hold_q    <= '0;
    end else begin
      state_q <= state_d;
      if (capture) begin
        hi_word_q <= addr[31:2] + 30'd1;
        funct3_q  <= funct3;
        we_q      <= req_we;
        sdata_q   <= store_data;
        off_q     <= off;
        hold_q    <= mem_rdata >> sh_lo;
      end
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit with a behavioural word memory and a queue of
// expected load results consumed whenever the DUT reports done.
module tb_load_store_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid, req_we;
  logic [2:0]  funct3;
  logic [31:0] addr, store_data;
  logic        busy, done, illegal, mem_we;
  logic [31:0] load_result, mem_addr, mem_wdata, mem_rdata;

  load_store_unit dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_we(req_we), .funct3(funct3),
    .addr(addr), .store_data(store_data), .busy(busy), .done(done), .illegal(illegal),
    .load_result(load_result), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  // Sixteen-word memory indexed by address bits [5:2]; the test addresses never alias.
  logic [31:0] mem [16];
  int          wr_count = 0;
  logic        bd_we = 1'b0;
  logic [3:0]  bd_idx = '0;
  logic [31:0] bd_data = '0;

  assign mem_rdata = mem[mem_addr[5:2]];

  always @(posedge clk) begin
    if (bd_we) mem[bd_idx] <= bd_data;
    else if (mem_we) begin
      mem[mem_addr[5:2]] <= mem_wdata;
      wr_count <= wr_count + 1;
    end
  end

  int          n_checks = 0;
  int          n_pass = 0;
  logic [31:0] sb [$];
  logic [31:0] addr_tr [4];
  logic        busy_tr [4];
  logic        illegal_tr [4];
  int          lat;
  int          wr0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  task automatic preload(input logic [3:0] idx, input logic [31:0] data);
    bd_we = 1'b1; bd_idx = idx; bd_data = data;
    @(posedge clk); #1;
    bd_we = 1'b0;
  endtask

  // Presents one request, then junk inputs from the second cycle on; pops the
  // expected load result when done appears. Entered and left at posedge + 1.
  task automatic access(input logic we, input logic [2:0] f3, input logic [31:0] a,
                        input logic [31:0] sd, input string tag);
    logic got = 1'b0;
    lat = 0;
    req_valid = 1'b1; req_we = we; funct3 = f3; addr = a; store_data = sd;
    for (int c = 0; c < 4 && !got; c++) begin
      @(negedge clk);
      addr_tr[c] = mem_addr; busy_tr[c] = busy; illegal_tr[c] = illegal;
      if (done) begin
        got = 1'b1;
        lat = c + 1;
        check({tag, " result"}, load_result, sb.pop_front());
      end
      @(posedge clk); #1;
      req_valid = 1'b0; req_we = 1'b1; funct3 = 3'b010;
      addr = 32'h0BAD_0006; store_data = 32'hFFFF_FFFF;
    end
    if (!got) begin
      check({tag, " done seen"}, {31'b0, got}, 32'd1);
      if (sb.size() > 0) void'(sb.pop_front());
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    req_valid = 1'b1; req_we = 1'b0; funct3 = 3'b010; addr = 32'h10; store_data = '0;
    #12;
    check("rst busy", busy, 0);
    check("rst done", done, 0);
    check("rst illegal", illegal, 0);
    check("rst mem_we", mem_we, 0);
    check("rst load_result", load_result, 0);
    req_valid = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    preload(4'd4, 32'h0);
    preload(4'd8, 32'h1122_3344);
    preload(4'd9, 32'h5566_7788);
    preload(4'd10, 32'h99AA_BBCC);
    preload(4'd15, 32'hAABB_CCDD);
    preload(4'd0, 32'h1122_3344);

    // Aligned word store then load
    sb.push_back(32'h0);
    access(1'b1, 3'b010, 32'h10, 32'hDEAD_BEEF, "SW 0x10");
    check("SW 0x10 mem", mem[4], 32'hDEAD_BEEF);
    check("SW 0x10 latency", lat, 1);
    check("SW 0x10 busy", busy_tr[0], 0);
    sb.push_back(32'hDEAD_BEEF);
    access(1'b0, 3'b010, 32'h10, 32'h0, "LW 0x10");
    check("LW 0x10 latency", lat, 1);
    check("LW 0x10 busy", busy_tr[0], 0);

    // Sub-word store merge and extension
    sb.push_back(32'h0);
    access(1'b1, 3'b000, 32'h21, 32'h0000_00AA, "SB 0x21");
    check("SB 0x21 mem", mem[8], 32'h1122_AA44);
    sb.push_back(32'hFFFF_FFAA);
    access(1'b0, 3'b000, 32'h21, 32'h0, "LB 0x21");
    sb.push_back(32'h0000_00AA);
    access(1'b0, 3'b100, 32'h21, 32'h0, "LBU 0x21");
    sb.push_back(32'h0000_1122);
    access(1'b0, 3'b001, 32'h22, 32'h0, "LH 0x22");
    sb.push_back(32'h0000_AA44);
    access(1'b0, 3'b101, 32'h20, 32'h0, "LHU 0x20");

    // Crossing halfword load
    preload(4'd8, 32'h1122_3344);
    sb.push_back(32'hFFFF_8811);
    access(1'b0, 3'b001, 32'h23, 32'h0, "LH 0x23");
    check("LH 0x23 latency", lat, 2);
    check("LH 0x23 c1 addr", addr_tr[0], 32'h20);
    check("LH 0x23 c1 busy", busy_tr[0], 1);
    check("LH 0x23 c2 addr", addr_tr[1], 32'h24);
    check("LH 0x23 c2 busy", busy_tr[1], 0);

    // Crossing word store
    wr0 = wr_count;
    sb.push_back(32'h0);
    access(1'b1, 3'b010, 32'h26, 32'hCAFE_BABE, "SW 0x26");
    check("SW 0x26 low word", mem[9], 32'hBABE_7788);
    check("SW 0x26 high word", mem[10], 32'h99AA_CAFE);
    check("SW 0x26 writes", wr_count - wr0, 2);
    check("SW 0x26 latency", lat, 2);

    // Same store with reset asserted during the second cycle
    preload(4'd9, 32'h5566_7788);
    preload(4'd10, 32'h99AA_BBCC);
    wr0 = wr_count;
    req_valid = 1'b1; req_we = 1'b1; funct3 = 3'b010; addr = 32'h26; store_data = 32'hCAFE_BABE;
    @(negedge clk);
    check("RST-SW c1 busy", busy, 1);
    check("RST-SW c1 mem_we", mem_we, 1);
    @(posedge clk); #1;
    req_valid = 1'b0;
    check("RST-SW c2 mem_we before rst", mem_we, 1);
    #2 rst = 1'b1;
    #1;
    check("RST-SW busy", busy, 0);
    check("RST-SW mem_we", mem_we, 0);
    check("RST-SW done", done, 0);
    @(posedge clk); #1;
    check("RST-SW low word", mem[9], 32'hBABE_7788);
    check("RST-SW high word", mem[10], 32'h99AA_BBCC);
    check("RST-SW writes", wr_count - wr0, 1);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;
    sb.push_back(32'hBABE_7788);
    access(1'b0, 3'b010, 32'h24, 32'h0, "LW after rst");
    check("LW after rst latency", lat, 1);

    // Illegal encodings
    wr0 = wr_count;
    sb.push_back(32'h0);
    access(1'b0, 3'b011, 32'h10, 32'h0, "ILL 011");
    check("ILL 011 illegal", illegal_tr[0], 1);
    check("ILL 011 latency", lat, 1);
    sb.push_back(32'h0);
    access(1'b1, 3'b100, 32'h10, 32'h1234_5678, "ILL SBU");
    check("ILL SBU illegal", illegal_tr[0], 1);
    check("ILL writes", wr_count - wr0, 0);
    check("ILL mem", mem[4], 32'hDEAD_BEEF);

    // Address wrap-around on a crossing word load
    sb.push_back(32'h3344_AABB);
    access(1'b0, 3'b010, 32'hFFFF_FFFE, 32'h0, "LW wrap");
    check("LW wrap c1 addr", addr_tr[0], 32'hFFFF_FFFC);
    check("LW wrap c2 addr", addr_tr[1], 32'h0000_0000);
    check("LW wrap latency", lat, 2);

    check("scoreboard drained", sb.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
